// File: rtl/adder_arb_pkg.sv
// Shared constants, FSM state type and saturation limits
// for the shared adder arbiter.
package adder_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DW_A_DEF    = 8;
  localparam int DW_B_DEF    = 8;
  localparam int DW_OUT_DEF  = 9;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: search upward from ptr with wrap,
// first asserted request wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic [IW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (en_i && !vld_o && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = j;
        vld_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_adder_arbiter.sv
// N requesters share one registered signed adder.
// Define ADDER_SATURATE_EN to clamp instead of wrap.
module shared_adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int DATA_WIDTH_A   = DW_A_DEF,
  parameter int DATA_WIDTH_B   = DW_B_DEF,
  parameter int DATA_WIDTH_OUT = DW_OUT_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*DATA_WIDTH_A-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH_B-1:0]   req_b,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [DATA_WIDTH_OUT-1:0]         res_sum,
  output logic [$clog2(NUM_REQ)-1:0]        res_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = DATA_WIDTH_OUT + 1;

  state_e                     state_q, state_d;
  logic [IW-1:0]              ptr_q, ptr_d;
  logic [IW-1:0]              id_q, id_d;
  logic [DATA_WIDTH_OUT-1:0]  sum_q, sum_d, sum_nx;

  logic                       en;
  logic [NUM_REQ-1:0]         gnt;
  logic [IW-1:0]              gidx;
  logic                       gvld;

  logic signed [DATA_WIDTH_A-1:0] a_sel;
  logic signed [DATA_WIDTH_B-1:0] b_sel;
  logic signed [SW-1:0]           a_ext, b_ext, sum_w;

  // A held result may be drained and replaced in the same cycle.
  assign en = rst_n & ((state_q == EMPTY) | res_ready);

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .en_i  (en),
    .gnt_o (gnt),
    .idx_o (gidx),
    .vld_o (gvld)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == IW'(i)) begin
        a_sel = req_a[i*DATA_WIDTH_A +: DATA_WIDTH_A];
        b_sel = req_b[i*DATA_WIDTH_B +: DATA_WIDTH_B];
      end
    end
  end

  assign a_ext = SW'(a_sel);
  assign b_ext = SW'(b_sel);
  assign sum_w = a_ext + b_ext;

`ifdef ADDER_SATURATE_EN
  localparam logic signed [SW-1:0] SMAX =
    SW'(sat_max(DATA_WIDTH_OUT));
  localparam logic signed [SW-1:0] SMIN =
    SW'(sat_min(DATA_WIDTH_OUT));

  always_comb begin
    sum_nx = sum_w[DATA_WIDTH_OUT-1:0];
    if (sum_w > SMAX)
      sum_nx = SMAX[DATA_WIDTH_OUT-1:0];
    else if (sum_w < SMIN)
      sum_nx = SMIN[DATA_WIDTH_OUT-1:0];
  end
`else
  assign sum_nx = sum_w[DATA_WIDTH_OUT-1:0];
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sum_d   = sum_q;
    if (gvld) begin
      state_d = FULL;
      ptr_d   = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
      id_d    = gidx;
      sum_d   = sum_nx;
    end else if (res_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
    end
  end

  assign req_ready = gnt;
  assign res_valid = (state_q == FULL);
  assign res_sum   = sum_q;
  assign res_id    = id_q;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed scoreboard bench for shared_adder_arbiter
// (4 requesters, 8/8/8 widths).
module tb_shared_adder_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_sum;
  logic [1:0]  res_id;

  logic signed [7:0] a_tb [4];
  logic signed [7:0] b_tb [4];

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] sum;
  } sb_t;

  sb_t sb [$];
  int  tests = 0;
  int  fails = 0;

  assign req_a = {a_tb[3], a_tb[2], a_tb[1], a_tb[0]};
  assign req_b = {b_tb[3], b_tb[2], b_tb[1], b_tb[0]};

  shared_adder_arbiter #(
    .NUM_REQ        (4),
    .DATA_WIDTH_A   (8),
    .DATA_WIDTH_B   (8),
    .DATA_WIDTH_OUT (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] exp_sum(
    input logic signed [7:0] a,
    input logic signed [7:0] b
  );
    int s;
    s = int'(a) + int'(b);
`ifdef ADDER_SATURATE_EN
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
`endif
    return 8'(s);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Drive one cycle, check outputs and grant, then clock.
  task automatic cycle(input logic [3:0] v,
                       input logic       rr,
                       input logic [3:0] eg);
    req_valid = v;
    res_ready = rr;
    #1;
    chk("res_valid", 32'(res_valid), 32'(sb.size() > 0));
    if (sb.size() > 0) begin
      chk("res_sum", 32'(res_sum), 32'(sb[0].sum));
      chk("res_id", 32'(res_id), 32'(sb[0].id));
      if (rr) void'(sb.pop_front());
    end
    chk("req_ready", 32'(req_ready), 32'(eg));
    for (int i = 0; i < 4; i++)
      if (eg[i])
        sb.push_back('{id: 2'(i),
                       sum: exp_sum(a_tb[i], b_tb[i])});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_tb[i] = '0;
      b_tb[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_sum", 32'(res_sum), 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);
    req_valid = 4'hF;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst_n     = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;

    // single request
    a_tb[0] = 8'sd5;
    b_tb[0] = -8'sd3;
    cycle(4'b0001, 1'b1, 4'b0001);
    cycle(4'b0000, 1'b1, 4'b0000);

    // fairness from ptr 0
    cycle(4'b1000, 1'b1, 4'b1000);
    a_tb[0] = 8'sd10;   b_tb[0] = 8'sd1;
    a_tb[1] = 8'sd20;   b_tb[1] = -8'sd2;
    a_tb[2] = -8'sd30;  b_tb[2] = 8'sd3;
    a_tb[3] = -8'sd100; b_tb[3] = -8'sd50;
    cycle(4'b1111, 1'b1, 4'b0001);
    cycle(4'b1111, 1'b1, 4'b0010);
    cycle(4'b1111, 1'b1, 4'b0100);
    cycle(4'b1111, 1'b1, 4'b1000);
    cycle(4'b1111, 1'b1, 4'b0001);
    cycle(4'b0000, 1'b1, 4'b0000);

    // backpressure
    cycle(4'b0001, 1'b0, 4'b0001);
    cycle(4'b0010, 1'b0, 4'b0000);
    cycle(4'b0010, 1'b0, 4'b0000);
    cycle(4'b0010, 1'b0, 4'b0000);
    cycle(4'b0010, 1'b1, 4'b0010);
    cycle(4'b0000, 1'b1, 4'b0000);

    // overflow / clamp
    a_tb[1] = 8'sd127;  b_tb[1] = 8'sd1;
    a_tb[2] = -8'sd128; b_tb[2] = -8'sd1;
    cycle(4'b0100, 1'b1, 4'b0100);
    cycle(4'b0010, 1'b1, 4'b0010);
    cycle(4'b0000, 1'b1, 4'b0000);

    // wrap and skip from ptr 3
    cycle(4'b0100, 1'b1, 4'b0100);
    cycle(4'b0101, 1'b1, 4'b0001);
    cycle(4'b0101, 1'b1, 4'b0100);
    cycle(4'b0000, 1'b1, 4'b0000);

    // reset mid-run
    cycle(4'b0001, 1'b0, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(res_valid), 32'd0);
    chk("midrst_sum", 32'(res_sum), 32'd0);
    sb.delete();
    req_valid = 4'hF;
    res_ready = 1'b1;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    cycle(4'b1111, 1'b1, 4'b0001);
    cycle(4'b0000, 1'b1, 4'b0000);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
